mips_main_fsm: RTL

- Multicycle main controller for the byte-fed MIPS datapath. It drives every select and write-enable the datapath consumes: IorD, MemWrite, IRWrite, RegWrite, ALUSrcA/B, ALUOp, PCSrc, Branch, PCWrite, RegDst, MemtoReg and fetch_en.
- It sits directly upstream of the instruction register and the datapath muxes.
- It fetches each 32-bit instruction as four bytes from the 8-bit instruction memory, then sequences decode, execute, memory and writeback per opcode.

---
 rtl/mips_ctrl_pkg.sv | 74 +++++++
 rtl/mips_ctrl_decode.sv | 72 +++++++
 rtl/mips_main_fsm.sv | 93 +++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller:
// state enum, opcode constants, datapath select codes and the control bundle.
package mips_ctrl_pkg;

  localparam int OPC_W = 6;

  typedef enum logic [4:0] {
    IDLE    = 5'd0,
    FETCH0  = 5'd1,
    FETCH1  = 5'd2,
    FETCH2  = 5'd3,
    FETCH3  = 5'd4,
    DECODE  = 5'd5,
    MEMADR  = 5'd6,
    MEMRD   = 5'd7,
    MEMWB   = 5'd8,
    MEMWR   = 5'd9,
    EXEC    = 5'd10,
    ALUWB   = 5'd11,
    BRANCH  = 5'd12,
    ADDIEX  = 5'd13,
    ADDIWB  = 5'd14,
    JUMP    = 5'd15,
    ILLEGAL = 5'd16
  } state_t;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       fetch_en;
    logic       iord;
    logic       mem_write;
    logic [3:0] ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       branch;
    logic       pc_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  function automatic state_t decode_next(input logic [OPC_W-1:0] op);
    case (op)
      OP_LW, OP_SW: return MEMADR;
      OP_RTYPE:     return EXEC;
      OP_BEQ:       return BRANCH;
      OP_ADDI:      return ADDIEX;
      OP_J:         return JUMP;
      default:      return ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure state -> control-vector table; everything not set for a state stays 0,
// including unused encodings and ILLEGAL.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH0, FETCH1, FETCH2, FETCH3: begin
        ctrl.fetch_en  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
        case (state)
          FETCH0:  ctrl.ir_write = 4'b0001;
          FETCH1:  ctrl.ir_write = 4'b0010;
          FETCH2:  ctrl.ir_write = 4'b0100;
          default: ctrl.ir_write = 4'b1000;
        endcase
      end
      // Precompute the branch target into ALUOut while the opcode is decoded.
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM4;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_WD;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_WD;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
      JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_fsm.sv
// Multicycle MIPS main controller: byte-wise fetch, decode, then per-opcode
// execute/memory/writeback. Moore outputs decoded from the state register.
module mips_main_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_RD_WAIT = 0
) (
  input  logic        clk_i_top,
  input  logic        rst_i_top,
  input  logic [31:0] instr,
  output logic        fetch_en,
  output logic        IorD,
  output logic        MemWrite,
  output logic [3:0]  IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSrc,
  output logic        Branch,
  output logic        PCWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        illegal_o
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_RD_WAIT);

  state_t           state;
  logic [OPC_W-1:0] opcode;
  logic [3:0]       wait_cnt;
  ctrl_t            ctrl;
  logic             unused_instr;

  assign unused_instr = ^instr[25:0];

  always_ff @(posedge clk_i_top or negedge rst_i_top) begin
    if (!rst_i_top) begin
      state     <= IDLE;
      opcode    <= '0;
      wait_cnt  <= '0;
      illegal_o <= 1'b0;
    end else begin
      case (state)
        IDLE:   state <= FETCH0;
        FETCH0: state <= FETCH1;
        FETCH1: state <= FETCH2;
        FETCH2: state <= FETCH3;
        FETCH3: state <= DECODE;
        DECODE: begin
          opcode <= instr[31:26];
          state  <= decode_next(instr[31:26]);
          if (decode_next(instr[31:26]) == ILLEGAL) illegal_o <= 1'b1;
        end
        MEMADR: state <= (opcode == OP_LW) ? MEMRD : MEMWR;
        // Hold in MEMRD for MEM_RD_WAIT extra cycles before writeback.
        MEMRD: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= MEMWB;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        EXEC:    state <= ALUWB;
        ADDIEX:  state <= ADDIWB;
        MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: state <= FETCH0;
        ILLEGAL: state <= ILLEGAL;
        default: state <= IDLE;
      endcase
    end
  end

  mips_ctrl_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  assign fetch_en = ctrl.fetch_en;
  assign IorD     = ctrl.iord;
  assign MemWrite = ctrl.mem_write;
  assign IRWrite  = ctrl.ir_write;
  assign RegWrite = ctrl.reg_write;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign PCSrc    = ctrl.pc_src;
  assign Branch   = ctrl.branch;
  assign PCWrite  = ctrl.pc_write;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;

endmodule
